// File: rtl/sram_line_fifo_ctrl.sv
// Line-packing FIFO controller in front of a single-port SRAM bank: packs
// words into lines on write and serializes lines back out in FIFO order.
//
//   state | meaning
//   IDLE  | output buffer empty, waiting for a stored line
//   WAIT  | read issued last cycle, bank Q captured at end of this cycle
//   DRAIN | output buffer holds a line, words presented one per pop
module sram_line_fifo_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          clk_en,
  input  logic                                          flush,
  input  logic [DATA_WIDTH-1:0]                         data_in,
  input  logic                                          data_in_valid,
  output logic                                          data_in_ready,
  output logic [DATA_WIDTH-1:0]                         data_out,
  output logic                                          data_out_valid,
  input  logic                                          data_out_ready,
  output logic [ADDR_WIDTH-1:0]                         mem_addr_in_bank,
  output logic                                          mem_cen_in_bank,
  output logic                                          mem_wen_in_bank,
  output logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0]        mem_data_in_bank,
  input  logic [0:0][FETCH_WIDTH-1:0][DATA_WIDTH-1:0]   mem_data_out_bank,
  output logic [ADDR_WIDTH:0]                           line_count,
  output logic                                          empty,
  output logic                                          full
);

  localparam int IDX_W = $clog2(FETCH_WIDTH);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(FETCH_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0]   LC_MAX   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} rd_state_t;

  rd_state_t r_state, w_state_nxt;

  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] r_wbuf;
  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] r_obuf;
  logic [IDX_W-1:0]                       r_wr_idx;
  logic [IDX_W-1:0]                       r_rd_idx;
  logic                                   r_wbuf_full;
  logic [ADDR_WIDTH-1:0]                  r_wr_ptr;
  logic [ADDR_WIDTH-1:0]                  r_rd_ptr;
  logic [ADDR_WIDTH:0]                    r_line_count;

  logic w_go;
  logic w_pop;
  logic w_last_pop;
  logic w_rd_req;
  logic w_wr_req;
  logic w_rd_gnt;
  logic w_wr_gnt;
  logic w_accept;

  // flush suppresses bank traffic so a flushed cycle never moves pointers
  assign w_go       = clk_en && !flush;
  assign w_pop      = clk_en && (r_state == DRAIN) && data_out_ready;
  assign w_last_pop = w_pop && (r_rd_idx == IDX_LAST);
  assign w_rd_req   = (r_line_count != '0) && ((r_state == IDLE) || w_last_pop);
  assign w_wr_req   = r_wbuf_full && (r_line_count != LC_MAX);
  assign w_rd_gnt   = w_go && w_rd_req;
  assign w_wr_gnt   = w_go && w_wr_req && !w_rd_req;
  assign w_accept   = w_go && data_in_valid && !r_wbuf_full;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rd_gnt) w_state_nxt = WAIT;
      WAIT:    w_state_nxt = DRAIN;
      DRAIN:   if (w_last_pop) w_state_nxt = w_rd_gnt ? WAIT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_state <= IDLE;
    else if (flush)  r_state <= IDLE;
    else if (clk_en) r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbuf       <= '0;
      r_obuf       <= '0;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_wbuf_full  <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_line_count <= '0;
    end else if (flush) begin
      r_wbuf       <= '0;
      r_obuf       <= '0;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_wbuf_full  <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_line_count <= '0;
    end else if (clk_en) begin
      if (w_accept) begin
        r_wbuf[r_wr_idx] <= data_in;
        r_wr_idx         <= r_wr_idx + IDX_W'(1);
        if (r_wr_idx == IDX_LAST) r_wbuf_full <= 1'b1;
      end
      if (w_wr_gnt) begin
        r_wbuf_full <= 1'b0;
        r_wr_ptr    <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_gnt)
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + ADDR_WIDTH'(1);
      if (w_wr_gnt && !w_rd_gnt)
        r_line_count <= r_line_count + (ADDR_WIDTH + 1)'(1);
      else if (w_rd_gnt && !w_wr_gnt)
        r_line_count <= r_line_count - (ADDR_WIDTH + 1)'(1);
      // bank Q is held while clk_en is low, so the capture may be stalled safely
      if (r_state == WAIT) begin
        r_obuf   <= mem_data_out_bank[0];
        r_rd_idx <= '0;
      end else if (w_pop) begin
        r_rd_idx <= r_rd_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    mem_cen_in_bank  = w_rd_gnt || w_wr_gnt;
    mem_wen_in_bank  = w_wr_gnt;
    mem_addr_in_bank = '0;
    if (w_rd_gnt)      mem_addr_in_bank = r_rd_ptr;
    else if (w_wr_gnt) mem_addr_in_bank = r_wr_ptr;
  end

  assign mem_data_in_bank = r_wbuf;
  assign data_in_ready    = clk_en && !r_wbuf_full;
  assign data_out_valid   = (r_state == DRAIN);
  assign data_out         = (r_state == DRAIN) ? r_obuf[r_rd_idx] : '0;
  assign line_count       = r_line_count;
  assign empty            = (r_line_count == '0) && (r_state == IDLE);
  assign full             = (r_line_count == LC_MAX) && r_wbuf_full;

endmodule

// File: tb/tb_sram_line_fifo_ctrl.sv
// Directed bench for sram_line_fifo_ctrl with a behavioural SRAM bank and a
// word scoreboard fed on input accepts and drained on output pops.
module tb_sram_line_fifo_ctrl;
  localparam int DW = 16, FW = 4, DEPTH = 256, AW = 8;

  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, flush = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic data_in_valid = 1'b0, data_in_ready;
  logic [DW-1:0] data_out;
  logic data_out_valid, data_out_ready = 1'b0;
  logic [AW-1:0] mem_addr_in_bank;
  logic mem_cen_in_bank, mem_wen_in_bank;
  logic [FW-1:0][DW-1:0] mem_data_in_bank;
  logic [0:0][FW-1:0][DW-1:0] mem_data_out_bank;
  logic [AW:0] line_count;
  logic empty, full;

  logic [FW-1:0][DW-1:0] bank [DEPTH];
  logic [FW-1:0][DW-1:0] bank_q = '0;

  int n_chk = 0, n_pass = 0, n_pop = 0, n_wr = 0, n_rd = 0;
  logic [AW-1:0] exp_wa = '0, exp_ra = '0;
  logic [DW-1:0] exp_q [$];

  sram_line_fifo_ctrl #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .mem_addr_in_bank(mem_addr_in_bank), .mem_cen_in_bank(mem_cen_in_bank),
    .mem_wen_in_bank(mem_wen_in_bank), .mem_data_in_bank(mem_data_in_bank),
    .mem_data_out_bank(mem_data_out_bank), .line_count(line_count),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  assign mem_data_out_bank[0] = bank_q;

  always @(posedge clk) begin
    if (mem_cen_in_bank) begin
      if (mem_wen_in_bank) bank[mem_addr_in_bank] <= mem_data_in_bank;
      else                 bank_q <= bank[mem_addr_in_bank];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard and bank-address model, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
      exp_wa = '0;
      exp_ra = '0;
    end else if (clk_en) begin
      if (mem_cen_in_bank) begin
        if (mem_wen_in_bank) begin
          check("wr_addr", 64'(mem_addr_in_bank), 64'(exp_wa));
          exp_wa++;
          n_wr++;
        end else begin
          check("rd_addr", 64'(mem_addr_in_bank), 64'(exp_ra));
          exp_ra++;
          n_rd++;
        end
      end
      if (data_in_valid && data_in_ready) exp_q.push_back(data_in);
      if (data_out_valid && data_out_ready) begin
        n_pop++;
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) check("sb_word", 64'(data_out), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    int cyc = 0;
    logic ok = 1'b0;
    data_in = w;
    data_in_valid = 1'b1;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      cyc++;
      ok = data_in_ready && clk_en;
    end
    check("push_tmo", 64'(ok), 64'(1));
    @(posedge clk); #1;
    data_in_valid = 1'b0;
  endtask

  task automatic pop_n(input int n);
    int got = 0, cyc = 0;
    data_out_ready = 1'b1;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (data_out_valid && clk_en) got++;
    end
    check("pop_tmo", 64'(got), 64'(n));
    @(posedge clk); #1;
    data_out_ready = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int cyc = 0;
    data_out_ready = 1'b1;
    while (exp_q.size() != 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 64'(exp_q.size()), 64'(0));
    repeat (3) @(negedge clk);
    check({tag, "_empty"}, 64'(empty), 64'(1));
    check({tag, "_lc"}, 64'(line_count), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic found;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(data_in_ready), 64'(1));
    check("rst_out_valid", 64'(data_out_valid), 64'(0));
    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_cen", 64'(mem_cen_in_bank), 64'(0));
    check("rst_wen", 64'(mem_wen_in_bank), 64'(0));
    check("rst_addr", 64'(mem_addr_in_bank), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    check("rst_lc", 64'(line_count), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // first line: write timing, read timing, word order
    data_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    @(negedge clk);
    check("t1_wr_cen", 64'(mem_cen_in_bank), 64'(1));
    check("t1_wr_wen", 64'(mem_wen_in_bank), 64'(1));
    check("t1_wr_addr", 64'(mem_addr_in_bank), 64'(0));
    check("t1_wr_line", 64'(mem_data_in_bank), 64'h0004_0003_0002_0001);
    @(negedge clk);
    check("t1_rd_cen", 64'(mem_cen_in_bank), 64'(1));
    check("t1_rd_wen", 64'(mem_wen_in_bank), 64'(0));
    check("t1_rd_addr", 64'(mem_addr_in_bank), 64'(0));
    @(negedge clk);
    check("t1_wait_valid", 64'(data_out_valid), 64'(0));
    @(negedge clk);
    check("t1_w0_valid", 64'(data_out_valid), 64'(1));
    check("t1_w0_data", 64'(data_out), 64'(1));
    repeat (6) @(negedge clk);
    check("t1_empty", 64'(empty), 64'(1));
    @(posedge clk); #1;

    // partial line stays invisible
    p0 = n_wr + n_rd;
    for (int i = 0; i < 3; i++) push_word(16'(100 + i));
    repeat (10) @(negedge clk);
    check("t2_no_access", 64'(n_wr + n_rd), 64'(p0));
    check("t2_lc", 64'(line_count), 64'(0));
    check("t2_empty", 64'(empty), 64'(1));
    check("t2_out_valid", 64'(data_out_valid), 64'(0));
    @(posedge clk); #1;

    // fill bank: 256 lines stored, one in the output buffer, one in the write buffer
    data_out_ready = 1'b0;
    for (int i = 0; i < 1029; i++) push_word(16'(1000 + i));
    @(negedge clk);
    check("t3_full", 64'(full), 64'(1));
    check("t3_lc", 64'(line_count), 64'(256));
    check("t3_in_ready", 64'(data_in_ready), 64'(0));
    @(posedge clk); #1;
    pop_n(4);
    found = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (mem_cen_in_bank && mem_wen_in_bank) found = 1'b1;
    end
    check("t3_wr_resume", 64'(found), 64'(1));
    check("t3_lc_after", 64'(line_count), 64'(256));
    check("t3_in_ready_after", 64'(data_in_ready), 64'(1));
    @(posedge clk); #1;

    // continuous streaming across pointer wrap
    data_out_ready = 1'b1;
    for (int i = 0; i < 2400; i++) push_word(16'(5000 + i));
    wait_drain("t4_drain");
    check("t4_writes", 64'(n_wr), 64'(859));
    check("t4_reads", 64'(n_rd), 64'(859));

    // flush while a read is in flight
    data_out_ready = 1'b0;
    for (int i = 0; i < 28; i++) push_word(16'(7000 + i));
    repeat (3) @(negedge clk);
    check("t5_lc_pre", 64'(line_count), 64'(6));
    check("t5_valid_pre", 64'(data_out_valid), 64'(1));
    @(posedge clk); #1;
    pop_n(4);
    flush = 1'b1;
    @(negedge clk);
    check("t5_lc_wait", 64'(line_count), 64'(5));
    check("t5_wait_valid", 64'(data_out_valid), 64'(0));
    check("t5_flush_cen", 64'(mem_cen_in_bank), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t5_lc", 64'(line_count), 64'(0));
    check("t5_valid", 64'(data_out_valid), 64'(0));
    check("t5_in_ready", 64'(data_in_ready), 64'(1));
    check("t5_empty", 64'(empty), 64'(1));
    p0 = n_pop;
    repeat (5) @(negedge clk);
    check("t5_no_pop", 64'(n_pop), 64'(p0));
    @(posedge clk); #1;
    data_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(16'(16'h0A00 + i));
    wait_drain("t5_drain");

    // clk_en stalls mid-DRAIN and during WAIT
    data_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(16'(8000 + i));
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    pop_n(2);
    clk_en = 1'b0;
    data_out_ready = 1'b1;
    p0 = n_pop;
    repeat (3) begin
      @(negedge clk);
      check("t6_drain_cen", 64'(mem_cen_in_bank), 64'(0));
      check("t6_drain_valid", 64'(data_out_valid), 64'(1));
      check("t6_drain_in_ready", 64'(data_in_ready), 64'(0));
    end
    check("t6_drain_no_pop", 64'(n_pop), 64'(p0));
    @(posedge clk); #1;
    clk_en = 1'b1;
    pop_n(2);
    clk_en = 1'b0;
    data_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_wait_cen", 64'(mem_cen_in_bank), 64'(0));
      check("t6_wait_valid", 64'(data_out_valid), 64'(0));
    end
    @(posedge clk); #1;
    clk_en = 1'b1;
    wait_drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
